// File: rtl/sopc_clk_rst_ctrl.sv
// sopc_clk_rst_ctrl: divided core/instruction clocks, core reset sequencing and a run/stop monitor
// that samples the core result on every core clock rising edge.
module sopc_clk_rst_ctrl #(
   parameter int INST_DIV   = 1,
   parameter int CORE_DIV   = 2,
   parameter int RST_HOLD   = 4,
   parameter int MAX_CYCLES = 0,
   parameter int RESULT_W   = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [RESULT_W-1:0] result,
   input  logic                halt_req,
   input  logic                restart,
   output logic                clk_core,
   output logic                clk_inst,
   output logic                core_rst,
   output logic                done,
   output logic [1:0]          stop_cause,
   output logic [31:0]         cycle_cnt,
   output logic [RESULT_W-1:0] result_q,
   output logic                result_chg,
   output logic [15:0]         chg_cnt
);
   localparam int IW = INST_DIV > 1 ? $clog2(INST_DIV) : 1;
   localparam int CW = CORE_DIV > 1 ? $clog2(CORE_DIV) : 1;
   localparam int HW = RST_HOLD > 1 ? $clog2(RST_HOLD) : 1;
   typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;
   state_t              state_q, state_d;
   logic [IW-1:0]       inst_cnt_q, inst_cnt_d;
   logic [CW-1:0]       core_cnt_q, core_cnt_d;
   logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
   logic                clk_inst_q, clk_inst_d, clk_core_q, clk_core_d;
   logic                core_rst_q, core_rst_d, done_q, done_d, chg_q, chg_d;
   logic [1:0]          stop_q, stop_d;
   logic [31:0]         cyc_q, cyc_d;
   logic [RESULT_W-1:0] res_q, res_d;
   logic [15:0]         chg_cnt_q, chg_cnt_d;
   logic                inst_run, core_run, inst_wrap, core_wrap, core_edge, limit, clear;

   // In DONE a divider only keeps running while its clock is low, so both clocks park high.
   always_comb begin
      inst_run   = state_q != DONE || !clk_inst_q;
      core_run   = state_q != DONE || !clk_core_q;
      inst_wrap  = inst_cnt_q == IW'(INST_DIV - 1);
      core_wrap  = core_cnt_q == CW'(CORE_DIV - 1);
      core_edge  = state_q == RUN && !clk_core_q && core_wrap;
      limit      = MAX_CYCLES != 0 && cyc_q == 32'(MAX_CYCLES);
      clear      = state_q == DONE && restart;
      inst_cnt_d = clear ? '0 : !inst_run ? inst_cnt_q : inst_wrap ? '0 : inst_cnt_q + 1'b1;
      core_cnt_d = clear ? '0 : !core_run ? core_cnt_q : core_wrap ? '0 : core_cnt_q + 1'b1;
      clk_inst_d = clear ? 1'b1 : inst_run && inst_wrap ? !clk_inst_q : clk_inst_q;
      clk_core_d = clear ? 1'b1 : core_run && core_wrap ? !clk_core_q : clk_core_q;
      hold_cnt_d = state_q == HOLD ? hold_cnt_q + 1'b1 : '0;
      state_d    = state_q == HOLD ? (hold_cnt_q == HW'(RST_HOLD - 1) ? RUN : HOLD) :
                   state_q == RUN  ? (halt_req || limit ? DONE : RUN) :
                   (restart ? HOLD : DONE);
      stop_d     = clear ? 2'b00 : state_q == RUN ? {limit, halt_req} : stop_q;
      cyc_d      = clear ? '0 : core_edge && cyc_q != '1 ? cyc_q + 32'd1 : cyc_q;
      chg_d      = core_edge && result != res_q;
      res_d      = clear ? '0 : core_edge ? result : res_q;
      chg_cnt_d  = clear ? '0 : chg_d && chg_cnt_q != '1 ? chg_cnt_q + 16'd1 : chg_cnt_q;
      core_rst_d = state_d == HOLD;
      done_d     = state_d == DONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= HOLD;
         inst_cnt_q <= '0;
         core_cnt_q <= '0;
         hold_cnt_q <= '0;
         clk_inst_q <= 1'b1;
         clk_core_q <= 1'b1;
         core_rst_q <= 1'b1;
         done_q     <= 1'b0;
         chg_q      <= 1'b0;
         stop_q     <= 2'b00;
         cyc_q      <= '0;
         res_q      <= '0;
         chg_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         inst_cnt_q <= inst_cnt_d;
         core_cnt_q <= core_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         clk_inst_q <= clk_inst_d;
         clk_core_q <= clk_core_d;
         core_rst_q <= core_rst_d;
         done_q     <= done_d;
         chg_q      <= chg_d;
         stop_q     <= stop_d;
         cyc_q      <= cyc_d;
         res_q      <= res_d;
         chg_cnt_q  <= chg_cnt_d;
      end
   end

   assign clk_core   = clk_core_q;
   assign clk_inst   = clk_inst_q;
   assign core_rst   = core_rst_q;
   assign done       = done_q;
   assign stop_cause = stop_q;
   assign cycle_cnt  = cyc_q;
   assign result_q   = res_q;
   assign result_chg = chg_q;
   assign chg_cnt    = chg_cnt_q;
endmodule

// File: tb/tb_sopc_clk_rst_ctrl.sv
// tb_sopc_clk_rst_ctrl: three instances (unlimited, 10-cycle and 5-cycle limit) driven by shared
// inputs; startup vectors, directed corner sequences and a randomized run against a phase model.
module tb_sopc_clk_rst_ctrl;
   localparam int CD = 2, ID = 1, RH = 4;
   localparam logic [86:0] RESET_VEC = {1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0, 32'h0, 32'h0};
   logic        clk = 1'b0, rst = 1'b1, halt_req = 1'b0, restart = 1'b0;
   logic [31:0] result = '0;
   logic        clk_core [3], clk_inst [3], core_rst [3], done [3], result_chg [3];
   logic [1:0]  stop_cause [3];
   logic [31:0] cycle_cnt [3], result_q [3];
   logic [15:0] chg_cnt [3];
   int          passed = 0, total = 0;
   int          m_mode [3], m_hold [3], m_kc [3], m_ki [3], m_chg [3];
   longint      m_cc [3];
   logic [31:0] m_res [3];
   logic [1:0]  m_sc [3];
   logic        m_pulse [3];
   typedef struct {
      logic        rst, halt;
      logic [31:0] res;
      logic        ci, cc, cr, dn;
      logic [31:0] cyc;
   } vec_t;
   vec_t tbl [12];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sopc_clk_rst_ctrl #(.MAX_CYCLES(g == 1 ? 10 : g == 2 ? 5 : 0)) u_dut (
         .clk(clk), .rst(rst), .result(result), .halt_req(halt_req), .restart(restart),
         .clk_core(clk_core[g]), .clk_inst(clk_inst[g]), .core_rst(core_rst[g]), .done(done[g]),
         .stop_cause(stop_cause[g]), .cycle_cnt(cycle_cnt[g]), .result_q(result_q[g]),
         .result_chg(result_chg[g]), .chg_cnt(chg_cnt[g])
      );
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   function automatic int max_of(int i);
      return i == 1 ? 10 : i == 2 ? 5 : 0;
   endfunction

   // A divided clock is high during even-numbered half-periods since its last restart.
   function automatic bit hi(int k, int d);
      return (k / d) % 2 == 0;
   endfunction

   task automatic model_step();
      bit ce, lim;
      for (int i = 0; i < 3; i++) begin
         m_pulse[i] = 1'b0;
         if (rst || (m_mode[i] == 2 && restart)) begin
            m_mode[i] = 0; m_hold[i] = 0; m_kc[i] = 0; m_ki[i] = 0;
            m_cc[i] = 0; m_res[i] = '0; m_chg[i] = 0; m_sc[i] = 2'b00;
         end else if (m_mode[i] == 0) begin
            m_kc[i]++; m_ki[i]++; m_hold[i]++;
            if (m_hold[i] == RH) m_mode[i] = 1;
         end else if (m_mode[i] == 1) begin
            ce  = (m_kc[i] + 1) % (2 * CD) == 0;
            lim = max_of(i) != 0 && m_cc[i] == max_of(i);
            m_kc[i]++; m_ki[i]++;
            if (ce) begin
               if (m_cc[i] < 64'hFFFF_FFFF) m_cc[i]++;
               if (result != m_res[i]) begin
                  m_res[i] = result;
                  m_pulse[i] = 1'b1;
                  if (m_chg[i] < 65535) m_chg[i]++;
               end
            end
            if (lim || halt_req) begin
               m_mode[i] = 2;
               m_sc[i] = {lim, halt_req};
            end
         end else begin
            if (!hi(m_kc[i], CD)) m_kc[i]++;
            if (!hi(m_ki[i], ID)) m_ki[i]++;
         end
      end
   endtask

   function automatic logic [86:0] model_vec(int i);
      return {hi(m_kc[i], CD), hi(m_ki[i], ID), m_mode[i] == 0, m_mode[i] == 2, m_sc[i], m_pulse[i],
              16'(m_chg[i]), 32'(m_cc[i]), m_res[i]};
   endfunction

   function automatic logic [86:0] dut_vec(int i);
      return {clk_core[i], clk_inst[i], core_rst[i], done[i], stop_cause[i], result_chg[i],
              chg_cnt[i], cycle_cnt[i], result_q[i]};
   endfunction

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; halt_req = 1'b0; restart = 1'b0; result = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic check_reset(string name);
      for (int i = 0; i < 3; i++) check($sformatf("%s_u%0d", name, i), dut_vec(i), RESET_VEC);
   endtask

   initial begin
      int n, hi_cnt, rises;
      logic prev, saw_ci, saw_cc;
      logic [31:0] c;
      logic [31:0] vals [4];
      tbl[0]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0};
      tbl[1]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0};
      tbl[2]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0};
      tbl[3]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0};
      tbl[4]  = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0};
      tbl[5]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0};
      tbl[6]  = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0};
      tbl[7]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
      tbl[8]  = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
      tbl[9]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
      tbl[10] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1};
      tbl[11] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1};
      vals = '{32'd1, 32'd2, 32'd2, 32'd3};

      tick();
      check_reset("reset");
      for (int r = 0; r < 12; r++) begin
         rst = tbl[r].rst; halt_req = tbl[r].halt; result = tbl[r].res;
         tick();
         check($sformatf("startup_row%0d", r), {clk_inst[0], clk_core[0], core_rst[0], done[0], cycle_cnt[0]},
               {tbl[r].ci, tbl[r].cc, tbl[r].cr, tbl[r].dn, tbl[r].cyc});
      end

      do_reset();
      n = 0;
      while (!done[1] && n < 200) begin tick(); n++; end
      check("limit10_done_latency", 32'(n), 32'd45);
      check("limit10_state", {stop_cause[1], chg_cnt[1], cycle_cnt[1]}, {2'b10, 16'd0, 32'd10});
      check("limit5_state", {done[2], stop_cause[2], cycle_cnt[2]}, {1'b1, 2'b10, 32'd5});
      repeat (3) tick();
      check("limit10_parked", {done[1], clk_core[1], clk_inst[1], cycle_cnt[1]}, {3'b111, 32'd10});

      do_reset();
      n = 0;
      while (cycle_cnt[2] != 32'd5 && n < 100) begin tick(); n++; end
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      check("both_causes", {done[2], stop_cause[2], cycle_cnt[2]}, {1'b1, 2'b11, 32'd5});
      check("halt_only", {done[0], stop_cause[0], cycle_cnt[0]}, {1'b1, 2'b01, 32'd5});

      do_reset();
      n = 0;
      while (core_rst[0] && n < 20) begin tick(); n++; end
      hi_cnt = 0; rises = 0; prev = 1'b0;
      foreach (vals[v]) begin
         result = vals[v];
         c = cycle_cnt[0];
         n = 0;
         while (cycle_cnt[0] == c && n < 20) begin
            tick(); n++;
            hi_cnt += int'(result_chg[0]);
            rises += int'(result_chg[0] && !prev);
            prev = result_chg[0];
         end
      end
      repeat (3) begin
         tick();
         hi_cnt += int'(result_chg[0]);
         rises += int'(result_chg[0] && !prev);
         prev = result_chg[0];
      end
      check("chg_pulse_cycles", 32'(hi_cnt), 32'd3);
      check("chg_pulse_count", 32'(rises), 32'd3);
      check("chg_final", {chg_cnt[0], result_q[0], cycle_cnt[0]}, {16'd3, 32'd3, 32'd4});

      do_reset();
      result = 32'd5;
      n = 0;
      while (cycle_cnt[0] < 32'd2 && n < 50) begin tick(); n++; end
      restart = 1'b1;
      tick();
      restart = 1'b0;
      check("restart_in_run", {done[0], core_rst[0], cycle_cnt[0] >= 32'd2}, 3'b001);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      repeat (3) tick();
      check("done_frozen", {done[0], clk_core[0], clk_inst[0], chg_cnt[0], result_q[0]}, {3'b111, 16'd1, 32'd5});
      restart = 1'b1;
      tick();
      restart = 1'b0;
      check("restart_clears", dut_vec(0), RESET_VEC);
      n = 0; saw_ci = 1'b0; saw_cc = 1'b0;
      while (core_rst[0] && n < 20) begin
         tick(); n++;
         saw_ci |= !clk_inst[0];
         saw_cc |= !clk_core[0];
      end
      check("restart_hold_len", 32'(n), 32'd4);
      check("restart_clocks_run", {saw_ci, saw_cc}, 2'b11);

      halt_req = 1'b1;
      tick();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      n = 0;
      while (!done[0] && n < 20) begin tick(); n++; end
      halt_req = 1'b0;
      check("halt_across_restart", {32'(n), stop_cause[0], cycle_cnt[0]}, {32'd5, 2'b01, 32'd0});

      do_reset();
      n = 0;
      while (cycle_cnt[0] != 32'd7 && n < 100) begin tick(); n++; end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset("mid_run_reset");

      do_reset();
      for (int k = 0; k < 3000; k++) begin
         rst = $urandom_range(0, 299) == 0;
         halt_req = $urandom_range(0, 59) == 0;
         restart = $urandom_range(0, 9) == 0;
         if ($urandom_range(0, 3) == 0) result = $urandom_range(0, 3);
         tick();
         for (int i = 0; i < 3; i++) check($sformatf("model_u%0d_cyc%0d", i, k), dut_vec(i), model_vec(i));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
